// File: rtl/fetch_pkg.sv
// Shared pipeline constants: bubble word, opcodes and fetch states.
// Imported by the fetch stage and its helpers.
package fetch_pkg;

  localparam logic [31:0] NOP_IR = 32'h6800_0000;

  localparam logic [4:0] OPC_NOP  = 5'b01101;
  localparam logic [4:0] OPC_B    = 5'b10010;
  localparam logic [4:0] OPC_BEQ  = 5'b10000;
  localparam logic [4:0] OPC_BGT  = 5'b10001;
  localparam logic [4:0] OPC_CALL = 5'b10011;
  localparam logic [4:0] OPC_RET  = 5'b10100;
  localparam logic [4:0] OPC_LD   = 5'b01110;
  localparam logic [4:0] OPC_ST   = 5'b01111;
  localparam logic [4:0] OPC_HLT  = 5'b11111;
  localparam logic [4:0] HLT_OPC  = OPC_HLT;

  typedef enum logic [1:0] {
    FILL,
    RUN,
    HALTED
  } fetch_state_e;

  function automatic logic [4:0] opcode(
    input logic [31:0] ir
  );
    return ir[31:27];
  endfunction

endpackage

// File: rtl/fetch_stage_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, IF/OF latch, flush/stall/halt control.
// Only imem_addr is combinational (alias of the PC).
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             isDataInterLock,
  input  logic             isBranchTaken,
  input  logic [31:0]      branchPC,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_data,
  output logic [31:0]      output_OF_IR,
  output logic [31:0]      output_OF_PC,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  fetch_state_e state, state_n;
  logic [31:0]  pc, pc_n;
  logic [31:0]  ir_n, ofpc_n;
  logic         halted_n;
  logic         stall_inc, flush_inc;

  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FILL;
      pc           <= RESET_PC;
      output_OF_IR <= NOP_IR;
      output_OF_PC <= '0;
      halted       <= 1'b0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      output_OF_IR <= ir_n;
      output_OF_PC <= ofpc_n;
      halted       <= halted_n;
    end
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    ir_n      = output_OF_IR;
    ofpc_n    = output_OF_PC;
    halted_n  = halted;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    unique case (state)
      FILL: begin
        ir_n    = imem_data;
        ofpc_n  = pc;
        pc_n    = pc + PC_STEP;
        state_n = RUN;
      end
      RUN: begin
        if (isBranchTaken) begin
          pc_n      = branchPC;
          ir_n      = NOP_IR;
          ofpc_n    = '0;
          flush_inc = 1'b1;
        end else if (isDataInterLock) begin
          stall_inc = 1'b1;
        end else begin
          ir_n   = imem_data;
          ofpc_n = pc;
          // HLT parks the PC on its own address
          if (opcode(imem_data) == HLT_OPC) begin
            state_n = HALTED;
          end else begin
            pc_n = pc + PC_STEP;
          end
        end
      end
      HALTED: begin
        if (isBranchTaken) begin
          pc_n      = branchPC;
          ir_n      = NOP_IR;
          ofpc_n    = '0;
          flush_inc = 1'b1;
          halted_n  = 1'b0;
          state_n   = RUN;
        end else begin
          halted_n = 1'b1;
          if (isDataInterLock) begin
            stall_inc = 1'b1;
          end else begin
            ir_n   = NOP_IR;
            ofpc_n = '0;
          end
        end
      end
      default: state_n = FILL;
    endcase
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/OF pipeline latch for the 5-stage pipeline (IF, OF, EX, MA, RW). It holds the PC, drives instruction-memory addresses, and latches fetched words into the OF-stage instruction register. That register is consumed by the data-interlock detector as `input_OF_IR`. It also consumes the detector's `isDataInterLock` stall and the EX-stage branch redirect, inserting NOP bubbles and tracking halt.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.
- `PC_STEP`, 4: sequential PC increment.
- `CNT_W`, 16: width of the stall and flush counters.
- `NOP_IR`, 32'h6800_0000: bubble word (opcode 5'b01101).
- `HLT_OPC`, 5'b11111: halt opcode.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `isDataInterLock` input 1: hold the PC and the OF latch this cycle.
- `isBranchTaken` input 1: EX stage resolved a taken branch, call or ret.
- `branchPC` input 32: redirect target, valid when `isBranchTaken`=1.
- `imem_addr` output 32: equals the PC register (combinational alias).
- `imem_data` input 32: instruction at `imem_addr`, same cycle (asynchronous read).
- `output_OF_IR` output 32: IF/OF instruction register.
- `output_OF_PC` output 32: PC of `output_OF_IR`.
- `halted` output 1: fetch stopped on a HLT.
- `stall_cnt` output CNT_W: cycles held by interlock (saturating).
- `flush_cnt` output CNT_W: redirects taken (saturating).

## Operation
- FSM states: FILL, RUN, HALTED.
- **Reset.** `rst`=1 at a clock edge sets:
  - PC=RESET_PC
  - `output_OF_IR`=NOP_IR, `output_OF_PC`=0
  - `halted`=0
  - both counters 0
  - state FILL
- **FILL.** Lasts exactly one cycle. The OF latch loads `imem_data` and PC+PC_STEP is taken; the state then moves to RUN. Interlock is ignored in this state because OF holds a NOP.
- **RUN.** Each cycle, the first matching rule applies:
  - **Flush** (`isBranchTaken`=1): PC←`branchPC`, `output_OF_IR`←NOP_IR, `output_OF_PC`←0, `flush_cnt`+1. Flush beats a simultaneous interlock; the interlock concerns a squashed instruction and `stall_cnt` does not increment.
  - **Stall** (`isDataInterLock`=1): PC, `output_OF_IR` and `output_OF_PC` hold; `stall_cnt`+1. Creating the EX bubble is the OF/EX latch's job, not this block's.
  - **Advance:** `output_OF_IR`←`imem_data`, `output_OF_PC`←PC, PC←PC+PC_STEP (mod 2^32; wraps 32'hFFFF_FFFC→0).
  - **Halt entry:** if the word latched on advance has `imem_data[31:27]`==HLT_OPC, the next state is HALTED. PC is not incremented that cycle, so it stays at the HLT address +0.
- **HALTED.**
  - PC holds and `halted`=1.
  - The OF latch loads NOP_IR every cycle after the HLT leaves OF; the HLT itself stays in OF until the first non-stalled cycle.
  - `isBranchTaken`=1 means the HLT was on a wrong path: apply the flush, clear `halted`, and go to RUN.
  - Interlock in HALTED holds the OF latch and increments `stall_cnt`.
- **Counters.** Both saturate at 2^CNT_W−1 and do not wrap.
- **Reset mid-operation.** Reset overrides every input in the same edge, including a pending flush or a HLT.

## Timing
- Fetch latency: an instruction at PC appears on `output_OF_IR` one edge after PC is driven.
- Redirect penalty: one NOP in OF. The target word is in OF two edges after the `isBranchTaken` cycle.
- `isDataInterLock` is sampled at the edge. A stall of N cycles keeps `output_OF_IR` constant for N+1 cycles in total.
- `halted` rises one edge after the HLT is latched into OF.
- No combinational path from any input to an output except `imem_addr`←PC.

## Structure
- Shared pipeline package holds: NOP_IR, the opcode constants (NOP 01101, B 10010, BEQ 10000, BGT 10001, CALL 10011, RET 10100, LD 01110, ST 01111, HLT 11111), and the state enum {FILL, RUN, HALTED}.
- One natural sub-module: `sat_counter` (CNT_W, inc, clear), instantiated twice.

## Test plan
- **Reset and sequential fetch:** assert then release reset, with imem returning addr-tagged words → FILL for 1 cycle; OF_IR sequence NOP, w(0), w(4), w(8); `output_OF_PC` 0, 4, 8.
- **Interlock:** hold `isDataInterLock` for 2 cycles while OF=w(8) → OF_IR stays w(8) for 3 cycles, `imem_addr` stays 12, `stall_cnt`=2.
- **Branch and interlock together:** `isBranchTaken`=1, `branchPC`=0x100, and `isDataInterLock`=1 in the same cycle → next OF_IR=NOP, PC=0x100, `flush_cnt`=1, `stall_cnt` unchanged; w(0x100) in OF one edge later.
- **Halt:** word at 0x20 has opcode 11111 → `halted`=1 one edge after OF=HLT, `imem_addr` frozen at 0x20, subsequent OF=NOP.
- **Recovery from HALTED:** in HALTED, pulse `isBranchTaken` with `branchPC`=0x40 → `halted`=0, state RUN, w(0x40) in OF two edges later.
- **Saturation and PC wrap:** CNT_W=2 with 5 stall cycles → `stall_cnt`=3. PC at 0xFFFF_FFFC advancing → next `imem_addr`=0.
